// File: rtl/debug_bus_master_if.sv
// debug_bus_master_if: UART byte streams and 6502-style bus signals of the debug bus master
interface debug_bus_master_if;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUS_REQ;
  logic        BUS_GNT;
  logic [15:0] A;
  logic [7:0]  DO;
  logic        R_W_n;
  logic [7:0]  DI;
  logic        BUSY;
  logic        OVERRUN;
  modport master (
    input  RX_DATA, RX_VALID, TX_READY, BUS_GNT, DI,
    output TX_DATA, TX_VALID, BUS_REQ, A, DO, R_W_n, BUSY, OVERRUN
  );
  modport slave (
    output RX_DATA, RX_VALID, TX_READY, BUS_GNT, DI,
    input  TX_DATA, TX_VALID, BUS_REQ, A, DO, R_W_n, BUSY, OVERRUN
  );
endinterface

// File: rtl/debug_bus_master.sv
// debug_bus_master: UART-command-driven single-byte bus reader/writer.
// DEBUG_BUS_AUTOINC_EN adds opcodes '+' (write) and '>' (read) at last address + 1.
module debug_bus_master #(
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic CLK,
  input logic RESET,
  debug_bus_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, GET_AH, GET_AL, GET_D, REQ, CYCLE, RESP} state_t;
  localparam logic [23:0] TMAX = 24'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [15:0] addr, a;
  logic [7:0]  data, dout, tx_data;
  logic        wr, rw, bus_req, tx_valid, overrun;
  logic [23:0] tout;
  logic [2:0]  lat;
  assign bus.TX_DATA  = tx_data;
  assign bus.TX_VALID = tx_valid;
  assign bus.BUS_REQ  = bus_req;
  assign bus.A        = a;
  assign bus.DO       = dout;
  assign bus.R_W_n    = rw;
  assign bus.BUSY     = state != IDLE;
  assign bus.OVERRUN  = overrun;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      addr     <= '0;
      a        <= '0;
      data     <= '0;
      dout     <= '0;
      tx_data  <= '0;
      wr       <= 1'b0;
      rw       <= 1'b1;
      bus_req  <= 1'b0;
      tx_valid <= 1'b0;
      overrun  <= 1'b0;
      tout     <= '0;
      lat      <= '0;
    end else begin
      if (bus.RX_VALID && (state == REQ || state == CYCLE || state == RESP)) overrun <= 1'b1;
      case (state)
        IDLE: if (bus.RX_VALID) begin
          tout <= '0;
          case (bus.RX_DATA)
            8'h52: begin wr <= 1'b0; state <= GET_AH; end
            8'h57: begin wr <= 1'b1; state <= GET_AH; end
`ifdef DEBUG_BUS_AUTOINC_EN
            8'h2B: begin wr <= 1'b1; addr <= a + 16'd1; state <= GET_D; end
            8'h3E: begin wr <= 1'b0; addr <= a + 16'd1; state <= REQ; end
`endif
            default: begin tx_data <= 8'h15; tx_valid <= 1'b1; state <= RESP; end
          endcase
        end
        GET_AH, GET_AL, GET_D: begin
          tout <= (bus.RX_VALID || tout == TMAX) ? '0 : tout + 24'd1;
          if (bus.RX_VALID) begin
            if (state == GET_AH) addr[15:8] <= bus.RX_DATA;
            if (state == GET_AL) addr[7:0] <= bus.RX_DATA;
            if (state == GET_D) data <= bus.RX_DATA;
            state <= state == GET_AH ? GET_AL : (state == GET_AL && wr) ? GET_D : REQ;
          end else if (tout == TMAX) state <= IDLE;
        end
        REQ: begin
          bus_req <= 1'b1;
          // grant only counts once our request is visible to the CPU
          if (bus_req && bus.BUS_GNT) begin
            a     <= addr;
            dout  <= wr ? data : dout;
            rw    <= !wr;
            lat   <= 3'd1;
            state <= CYCLE;
          end
        end
        CYCLE: begin
          if (wr || lat == 3'(READ_LATENCY)) begin
            rw       <= 1'b1;
            bus_req  <= 1'b0;
            tx_data  <= wr ? 8'h06 : bus.DI;
            tx_valid <= 1'b1;
            state    <= RESP;
          end else lat <= lat + 3'd1;
        end
        RESP: if (bus.TX_READY) begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_bus_master.sv
// tb_debug_bus_master: directed command vectors against debug_bus_master with a
// latency-2 responder model; covers write, read, NAK, timeout, grant stall and reset.
module tb_debug_bus_master;
  logic clk, rst, gnt_en;
  logic [7:0] d1;
  int checks = 0, errors = 0;
  int wr_cyc = 0, req_cyc = 0, tx_cnt = 0;
  logic [15:0] last_wa;
  logic [7:0] last_wd, last_tx;
  logic [7:0] mem [logic [15:0]];
  debug_bus_master_if bus();
  debug_bus_master #(.READ_LATENCY(2), .TIMEOUT_CYCLES(40)) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  assign bus.BUS_GNT = gnt_en & bus.BUS_REQ;
  assign bus.DI = d1;
  function automatic logic [7:0] rom(input logic [15:0] ad);
    return ad == 16'hE000 ? 8'h4C : ad == 16'h0000 ? 8'h3C : ad == 16'h0001 ? 8'h5A : ad[7:0] ^ 8'h33;
  endfunction
  always @(posedge clk) d1 <= mem.exists(bus.A) ? mem[bus.A] : rom(bus.A);
  always @(negedge clk) begin
    if (bus.R_W_n === 1'b0) begin
      wr_cyc++;
      mem[bus.A] = bus.DO;
      last_wa = bus.A;
      last_wd = bus.DO;
    end
    if (bus.BUS_REQ === 1'b1) req_cyc++;
    if (bus.TX_VALID === 1'b1 && bus.TX_READY) begin
      tx_cnt++;
      last_tx = bus.TX_DATA;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.RX_DATA = b;
    bus.RX_VALID = 1'b1;
    @(posedge clk);
    #1 bus.RX_VALID = 1'b0;
  endtask
  task automatic wait_tx(input int n0, input string tag, input logic [7:0] exp);
    int i = 0;
    while (tx_cnt == n0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    check({tag, "_cnt"}, tx_cnt - n0, 1);
    check(tag, last_tx, exp);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n0, w0, r0;
    rst = 1; gnt_en = 1;
    bus.RX_VALID = 0; bus.RX_DATA = 0; bus.TX_READY = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", bus.TX_DATA, 8'h00);
    check("rst_tx_valid", bus.TX_VALID, 0);
    check("rst_bus_req", bus.BUS_REQ, 0);
    check("rst_a", bus.A, 16'h0000);
    check("rst_do", bus.DO, 8'h00);
    check("rst_rw", bus.R_W_n, 1);
    check("rst_busy", bus.BUSY, 0);
    check("rst_overrun", bus.OVERRUN, 0);
    rst = 0;
    send(8'h57); send(8'h00); send(8'h10); send(8'hA5);
    check("wr_req_n", bus.BUS_REQ, 0);
    check("wr_busy", bus.BUSY, 1);
    @(posedge clk); #1;
    check("wr_req_n1", bus.BUS_REQ, 1);
    check("wr_rw_pre", bus.R_W_n, 1);
    @(posedge clk); #1;
    check("wr_rw", bus.R_W_n, 0);
    check("wr_a", bus.A, 16'h0010);
    check("wr_do", bus.DO, 8'hA5);
    @(posedge clk); #1;
    check("wr_rw_end", bus.R_W_n, 1);
    check("wr_tx_valid", bus.TX_VALID, 1);
    check("wr_tx_data", bus.TX_DATA, 8'h06);
    check("wr_req_drop", bus.BUS_REQ, 0);
    @(posedge clk); #1;
    check("wr_tx_done", bus.TX_VALID, 0);
    check("wr_idle", bus.BUSY, 0);
    check("wr_cycles", wr_cyc, 1);
    check("wr_tx_cnt", tx_cnt, 1);
    bus.TX_READY = 0;
    n0 = tx_cnt;
    send(8'h52); send(8'hE0); send(8'h00);
    for (int i = 0; i < 50 && !bus.TX_VALID; i++) begin
      @(posedge clk); #1;
    end
    check("rd_valid", bus.TX_VALID, 1);
    check("rd_data", bus.TX_DATA, 8'h4C);
    check("rd_a", bus.A, 16'hE000);
    check("rd_rw", bus.R_W_n, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rd_hold", bus.TX_VALID, 1);
    check("rd_no_hs", tx_cnt - n0, 0);
    bus.TX_READY = 1;
    wait_tx(n0, "rd", 8'h4C);
    check("rd_no_write", wr_cyc, 1);
    n0 = tx_cnt; r0 = req_cyc;
    send(8'h99);
    wait_tx(n0, "nak", 8'h15);
    check("nak_no_req", req_cyc - r0, 0);
`ifdef DEBUG_BUS_AUTOINC_EN
    n0 = tx_cnt;
    send(8'h57); send(8'hFF); send(8'hFF); send(8'h11);
    wait_tx(n0, "ai_w", 8'h06);
    check("ai_w_a", last_wa, 16'hFFFF);
    w0 = wr_cyc; n0 = tx_cnt;
    send(8'h2B); send(8'h22);
    wait_tx(n0, "ai_inc", 8'h06);
    check("ai_inc_a", last_wa, 16'h0000);
    check("ai_inc_d", last_wd, 8'h22);
    check("ai_inc_n", wr_cyc - w0, 1);
    n0 = tx_cnt;
    send(8'h3E);
    wait_tx(n0, "ai_rd", 8'h5A);
`else
    n0 = tx_cnt; r0 = req_cyc;
    send(8'h2B);
    wait_tx(n0, "noai_plus", 8'h15);
    n0 = tx_cnt;
    send(8'h3E);
    wait_tx(n0, "noai_gt", 8'h15);
    check("noai_no_req", req_cyc - r0, 0);
`endif
    n0 = tx_cnt; w0 = wr_cyc; r0 = req_cyc;
    send(8'h57); send(8'h12);
    repeat (38) @(posedge clk);
    #1;
    check("to_busy_before", bus.BUSY, 1);
    repeat (3) @(posedge clk);
    #1;
    check("to_idle", bus.BUSY, 0);
    check("to_no_tx", tx_cnt - n0, 0);
    check("to_no_wr", wr_cyc - w0, 0);
    check("to_no_req", req_cyc - r0, 0);
    n0 = tx_cnt;
    send(8'h52); send(8'h00); send(8'h00);
    wait_tx(n0, "to_after", 8'h3C);
    gnt_en = 0;
    n0 = tx_cnt; w0 = wr_cyc;
    send(8'h52); send(8'h00); send(8'h10);
    repeat (20) @(posedge clk);
    send(8'h77);
    repeat (80) @(posedge clk);
    #1;
    check("gnt_overrun", bus.OVERRUN, 1);
    check("gnt_req", bus.BUS_REQ, 1);
    check("gnt_rw", bus.R_W_n, 1);
    check("gnt_no_tx", tx_cnt - n0, 0);
    check("gnt_no_wr", wr_cyc - w0, 0);
    gnt_en = 1;
    wait_tx(n0, "gnt_rd", 8'hA5);
    gnt_en = 0;
    n0 = tx_cnt;
    send(8'h57); send(8'h01); send(8'h02); send(8'h03);
    repeat (3) @(posedge clk);
    #1;
    check("mid_req", bus.BUS_REQ, 1);
    rst = 1;
    @(posedge clk); #1;
    check("mid_req_clr", bus.BUS_REQ, 0);
    check("mid_rw", bus.R_W_n, 1);
    check("mid_busy", bus.BUSY, 0);
    check("mid_overrun", bus.OVERRUN, 0);
    check("mid_tx_valid", bus.TX_VALID, 0);
    rst = 0; gnt_en = 1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_no_tx", tx_cnt - n0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
